// File: rtl/instr_fetch_if.sv
// Fetch-stage bus bundle: PC/imem inputs, decoded redirect outputs, IR outputs and perf counters.
// slave = the fetch stage itself, master = the PC/memory/decode side.
interface instr_fetch_if;
    logic [7:0]  pc_addr;
    logic [7:0]  imem_addr;
    logic [15:0] imem_rdata;
    logic        zero_flag;
    logic        jump;
    logic        jump_zero;
    logic [7:0]  jump_addr;
    logic [15:0] ir;
    logic [7:0]  ir_pc;
    logic        ir_valid;
    logic        halted;
    logic [15:0] perf_fetched;
    logic [15:0] perf_squashed;

    modport slave (
        input  pc_addr, imem_rdata, zero_flag,
        output imem_addr, jump, jump_zero, jump_addr, ir, ir_pc, ir_valid, halted,
               perf_fetched, perf_squashed
    );

    modport master (
        output pc_addr, imem_rdata, zero_flag,
        input  imem_addr, jump, jump_zero, jump_addr, ir, ir_pc, ir_valid, halted,
               perf_fetched, perf_squashed
    );
endinterface

// File: rtl/instr_fetch.sv
// Instruction fetch stage: IR capture, local control-flow decode, one-bubble squash, sticky HALT.
// Optional saturating perf counters are built only when IFETCH_PERF_EN is defined.
//
// state | meaning
// RUN   | IR loads the PC word every edge; redirects decoded from a valid IR
// FLUSH | IR holds the wrong-path word (invalid); next edge loads the branch target
// HALT  | PC pinned to halt_pc via jump; IR frozen and invalid until reset
module instr_fetch (
    input  logic          clk,
    input  logic          reset_n,
    instr_fetch_if.slave  bus
);
    localparam logic [3:0] OPC_JMP  = 4'hE;
    localparam logic [3:0] OPC_JZ   = 4'hF;
    localparam logic [3:0] OPC_HALT = 4'hD;

    typedef enum logic [1:0] {S_RUN, S_FLUSH, S_HALT} state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [15:0] r_ir;
    logic [7:0]  r_ir_pc;
    logic [7:0]  r_halt_pc;
    logic        r_ir_valid;

    logic [3:0]  w_opc;
    logic        w_is_jmp;
    logic        w_is_jz;
    logic        w_is_halt;
    logic        w_jump;
    logic        w_jump_zero;
    logic        w_taken;
    logic [7:0]  w_jump_addr;
    logic        w_load_ir;
    logic        w_valid_nxt;
    logic        w_halt_capture;

    assign w_opc     = r_ir[15:12];
    assign w_is_jmp  = r_ir_valid & (w_opc == OPC_JMP);
    assign w_is_jz   = r_ir_valid & (w_opc == OPC_JZ);
    assign w_is_halt = r_ir_valid & (w_opc == OPC_HALT);

    // HALT reuses the unconditional redirect path to park the PC on itself.
    assign w_jump      = w_is_jmp | w_is_halt | (r_state == S_HALT);
    assign w_jump_zero = w_is_jz;
    assign w_taken     = w_jump | (w_jump_zero & bus.zero_flag);

    always_comb begin
        w_jump_addr = 8'h00;
        if (r_state == S_HALT)
            w_jump_addr = r_halt_pc;
        else if (w_is_jmp | w_is_jz)
            w_jump_addr = r_ir[7:0];
        else if (w_is_halt)
            w_jump_addr = r_ir_pc;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            r_state <= S_RUN;
        else
            r_state <= w_state_nxt;
    end

    // A valid HALT also raises taken, so it must win over the ordinary flush.
    always_comb begin
        w_state_nxt    = r_state;
        w_load_ir      = 1'b0;
        w_valid_nxt    = r_ir_valid;
        w_halt_capture = 1'b0;
        case (r_state)
            S_RUN: begin
                w_load_ir = 1'b1;
                if (w_is_halt) begin
                    w_state_nxt    = S_HALT;
                    w_valid_nxt    = 1'b0;
                    w_halt_capture = 1'b1;
                end else if (w_taken) begin
                    w_state_nxt = S_FLUSH;
                    w_valid_nxt = 1'b0;
                end else begin
                    w_valid_nxt = 1'b1;
                end
            end
            S_FLUSH: begin
                w_load_ir   = 1'b1;
                w_valid_nxt = 1'b1;
                w_state_nxt = S_RUN;
            end
            S_HALT: begin
                w_valid_nxt = 1'b0;
            end
            default: begin
                w_state_nxt = S_RUN;
                w_valid_nxt = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_ir       <= 16'h0000;
            r_ir_pc    <= 8'h00;
            r_ir_valid <= 1'b0;
            r_halt_pc  <= 8'h00;
        end else begin
            if (w_load_ir) begin
                r_ir    <= bus.imem_rdata;
                r_ir_pc <= bus.pc_addr;
            end
            r_ir_valid <= w_valid_nxt;
            if (w_halt_capture)
                r_halt_pc <= r_ir_pc;
        end
    end

    assign bus.imem_addr = bus.pc_addr;
    assign bus.jump      = w_jump;
    assign bus.jump_zero = w_jump_zero;
    assign bus.jump_addr = w_jump_addr;
    assign bus.ir        = r_ir;
    assign bus.ir_pc     = r_ir_pc;
    assign bus.ir_valid  = r_ir_valid;
    assign bus.halted    = (r_state == S_HALT);

`ifdef IFETCH_PERF_EN
    logic [15:0] r_perf_fetched;
    logic [15:0] r_perf_squashed;
    logic        w_fetch_inc;
    logic        w_squash_inc;

    assign w_fetch_inc  = w_load_ir & w_valid_nxt;
    assign w_squash_inc = (r_state == S_RUN) & w_taken;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_perf_fetched  <= 16'h0000;
            r_perf_squashed <= 16'h0000;
        end else begin
            if (w_fetch_inc && (r_perf_fetched != 16'hFFFF))
                r_perf_fetched <= r_perf_fetched + 16'd1;
            if (w_squash_inc && (r_perf_squashed != 16'hFFFF))
                r_perf_squashed <= r_perf_squashed + 16'd1;
        end
    end

    assign bus.perf_fetched  = r_perf_fetched;
    assign bus.perf_squashed = r_perf_squashed;
`else
    assign bus.perf_fetched  = 16'h0000;
    assign bus.perf_squashed = 16'h0000;
`endif
endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: behavioural PC and memory around the DUT, checked every cycle against
// a program-level model (fetch address, one-bubble redirect, sticky halt, saturating counters).
module tb_instr_fetch;
    localparam logic [3:0] OPC_JMP  = 4'hE;
    localparam logic [3:0] OPC_JZ   = 4'hF;
    localparam logic [3:0] OPC_HALT = 4'hD;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [7:0]  pc;
    logic [15:0] mem [256];

    instr_fetch_if bus ();

    instr_fetch dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    assign bus.pc_addr    = pc;
    assign bus.imem_rdata = mem[bus.imem_addr];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            pc <= 8'h00;
        else if (bus.jump | (bus.jump_zero & bus.zero_flag))
            pc <= bus.jump_addr;
        else
            pc <= pc + 8'd1;
    end

    int n_pass  = 0;
    int n_total = 0;
    int zf_mode = 0;   // 0: zero_flag low, 1: high, 2: random

    // reference model state
    logic [15:0] e_ir;
    logic [7:0]  e_ir_pc;
    logic        e_valid;
    logic        e_halted;
    logic [7:0]  e_halt_pc;
    logic [7:0]  m_fetch;
    logic [15:0] m_fet;
    logic [15:0] m_sq;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic model_reset();
        e_ir = 16'h0000; e_ir_pc = 8'h00; e_valid = 1'b0; e_halted = 1'b0;
        e_halt_pc = 8'h00; m_fetch = 8'h00; m_fet = 16'h0000; m_sq = 16'h0000;
    endtask

    // One clock edge of program semantics: the PC presents m_fetch, the IR takes that word.
    task automatic model_edge(input logic zf);
        logic [3:0] op;
        logic [7:0] a;
        op = e_ir[15:12];
        a  = m_fetch;
        if (e_halted) begin
            m_fetch = e_halt_pc;
        end else if (e_valid && op == OPC_HALT) begin
            e_halted  = 1'b1;
            e_halt_pc = e_ir_pc;
            m_fetch   = e_ir_pc;
            e_ir = mem[a]; e_ir_pc = a; e_valid = 1'b0;
            if (m_sq != 16'hFFFF) m_sq++;
        end else if (e_valid && (op == OPC_JMP || (op == OPC_JZ && zf))) begin
            m_fetch = e_ir[7:0];
            e_ir = mem[a]; e_ir_pc = a; e_valid = 1'b0;
            if (m_sq != 16'hFFFF) m_sq++;
        end else begin
            e_ir = mem[a]; e_ir_pc = a; e_valid = 1'b1;
            m_fetch = a + 8'd1;
            if (m_fet != 16'hFFFF) m_fet++;
        end
    endtask

    task automatic check_all(input string ph);
        logic [3:0]  op;
        logic        x_jump, x_jz;
        logic [7:0]  x_addr;
        logic [15:0] x_pf, x_ps;
        op     = e_ir[15:12];
        x_jump = e_halted | (e_valid & (op == OPC_JMP || op == OPC_HALT));
        x_jz   = !e_halted & e_valid & (op == OPC_JZ);
        x_addr = e_halted ? e_halt_pc : ((op == OPC_HALT) ? e_ir_pc : e_ir[7:0]);
`ifdef IFETCH_PERF_EN
        x_pf = m_fet; x_ps = m_sq;
`else
        x_pf = 16'h0000; x_ps = 16'h0000;
`endif
        chk({ph, ".ir_valid"}, 32'(bus.ir_valid), 32'(e_valid));
        chk({ph, ".halted"}, 32'(bus.halted), 32'(e_halted));
        chk({ph, ".pc"}, 32'(pc), 32'(m_fetch));
        chk({ph, ".imem_addr"}, 32'(bus.imem_addr), 32'(m_fetch));
        chk({ph, ".jump"}, 32'(bus.jump), 32'(x_jump));
        chk({ph, ".jump_zero"}, 32'(bus.jump_zero), 32'(x_jz));
        if (!e_halted) begin
            chk({ph, ".ir_pc"}, 32'(bus.ir_pc), 32'(e_ir_pc));
            chk({ph, ".ir"}, 32'(bus.ir), 32'(e_ir));
        end
        if (x_jump || x_jz)
            chk({ph, ".jump_addr"}, 32'(bus.jump_addr), 32'(x_addr));
        chk({ph, ".perf_fetched"}, 32'(bus.perf_fetched), 32'(x_pf));
        chk({ph, ".perf_squashed"}, 32'(bus.perf_squashed), 32'(x_ps));
    endtask

    // Starts and ends between edges (at a falling edge).
    task automatic step(input string ph, input int n);
        for (int i = 0; i < n; i++) begin
            case (zf_mode)
                0:       bus.zero_flag = 1'b0;
                1:       bus.zero_flag = 1'b1;
                default: bus.zero_flag = 1'($urandom_range(0, 1));
            endcase
            @(posedge clk);
            model_edge(bus.zero_flag);
            #1 check_all(ph);
            @(negedge clk);
        end
    endtask

    task automatic do_reset(input string ph);
        reset_n = 1'b0;
        model_reset();
        #1 check_all(ph);
        chk({ph, ".jump_addr_rst"}, 32'(bus.jump_addr), 32'h0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic load_nops();
        for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
    endtask

    task automatic load_random();
        int r;
        for (int i = 0; i < 256; i++) begin
            r = int'($urandom_range(0, 99));
            if (r < 8)
                mem[i] = {OPC_JMP, 4'($urandom), 8'($urandom)};
            else if (r < 16)
                mem[i] = {OPC_JZ, 4'($urandom), 8'($urandom)};
            else if (r < 18)
                mem[i] = {OPC_HALT, 12'h000};
            else
                mem[i] = {4'($urandom_range(0, 12)), 12'($urandom)};
        end
    endtask

    initial begin
        bus.zero_flag = 1'b0;
        load_nops();
        model_reset();
        @(negedge clk);

        // sequential NOPs from address 0
        do_reset("rst");
        step("seq", 4);

        // unconditional jump with one bubble
        load_nops(); mem[2] = 16'hE040;
        do_reset("jmp_rst");
        step("jmp", 7);

        // JZ taken, then not taken
        load_nops(); mem[5] = 16'hF010; zf_mode = 1;
        do_reset("jz1_rst");
        step("jz_taken", 9);
        zf_mode = 0;
        do_reset("jz0_rst");
        step("jz_not", 9);

        // sticky halt, then reset resumes from 0
        load_nops(); mem[7] = 16'hD000;
        do_reset("halt_rst");
        step("halt", 16);
        do_reset("halt_exit");
        step("halt_resume", 3);

        // back-to-back jumps: second one squashed
        load_nops(); mem[2] = 16'hE020; mem[3] = 16'hE030;
        do_reset("b2b_rst");
        step("b2b", 8);

        // asynchronous reset in the flush bubble
        load_nops(); mem[2] = 16'hE040;
        do_reset("aflush_rst");
        step("aflush", 4);
        #2 reset_n = 1'b0;
        model_reset();
        #1 check_all("aflush_async");
        @(negedge clk); reset_n = 1'b1;
        step("aflush_after", 2);

        // asynchronous reset while halted
        load_nops(); mem[7] = 16'hD000;
        do_reset("ahalt_rst");
        step("ahalt", 12);
        #3 reset_n = 1'b0;
        model_reset();
        #1 check_all("ahalt_async");
        @(negedge clk); reset_n = 1'b1;
        step("ahalt_after", 2);

        // random programs with random zero_flag
        zf_mode = 2;
        for (int p = 0; p < 20; p++) begin
            load_random();
            do_reset("rnd_rst");
            step("rnd", 100);
        end
        zf_mode = 0;

`ifdef IFETCH_PERF_EN
        // counter saturation over a long NOP run
        load_nops();
        do_reset("sat_rst");
        step("sat", 65540);
        chk("sat.final", 32'(bus.perf_fetched), 32'h0000FFFF);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
